// File: rtl/div_8x4.sv
// Sequential restoring divider: NW-bit dividend / DW-bit divisor -> NW-bit quotient, DW-bit remainder.
// Shares the start/Finish handshake of mult_4x4; divide-by-zero finishes on the capture edge.
module div_8x4 #(
    parameter int unsigned NW = 8,
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [NW-1:0] A,
    input  logic [DW-1:0] B,
    output logic [NW-1:0] Q,
    output logic [DW-1:0] R,
    output logic          Finish,
    output logic          Dz
);

    localparam int unsigned CW = $clog2(NW + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state;
    logic [NW-1:0] dvd;
    logic [NW-1:0] quo;
    logic [DW-1:0] dvs;
    logic [DW:0]   pr;
    logic [CW-1:0] count;

    logic [DW:0]   shifted;
    logic [DW:0]   next_pr;
    logic          q_bit;
    logic [NW-1:0] next_quo;

    // One restoring step: the partial remainder stays below the divisor, so dropping
    // its top bit on the shift loses nothing.
    always_comb begin
        shifted  = (DW + 1)'({pr, dvd[NW-1]});
        q_bit    = (shifted >= {1'b0, dvs});
        next_pr  = q_bit ? (shifted - {1'b0, dvs}) : shifted;
        next_quo = NW'({quo, q_bit});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            dvd    <= '0;
            quo    <= '0;
            dvs    <= '0;
            pr     <= '0;
            count  <= '0;
            Q      <= '0;
            R      <= '0;
            Finish <= 1'b0;
            Dz     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd   <= A;
                        dvs   <= B;
                        pr    <= '0;
                        quo   <= '0;
                        count <= '0;
                        if (B == '0) begin
                            Q      <= '1;
                            R      <= '0;
                            Dz     <= 1'b1;
                            Finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    dvd   <= dvd << 1;
                    pr    <= next_pr;
                    quo   <= next_quo;
                    count <= count + 1'b1;
                    if (count == CW'(NW - 1)) begin
                        Q      <= next_quo;
                        R      <= next_pr[DW-1:0];
                        Dz     <= 1'b0;
                        Finish <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (!start) begin
                        Finish <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_8x4.sv
// Scoreboard bench for div_8x4: expected quotient/remainder/latency queued at launch,
// popped and compared when Finish rises.
module tb_div_8x4;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] A;
    logic [3:0] B;
    logic [7:0] Q;
    logic [3:0] R;
    logic       Finish;
    logic       Dz;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    div_8x4 #(.NW(8), .DW(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .Q      (Q),
        .R      (R),
        .Finish (Finish),
        .Dz     (Dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request, queue its expected result, and pass the capture edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b);
        exp_t e;
        e.dz  = (b == 4'd0);
        e.q   = e.dz ? 8'hFF : 8'(int'(a) / int'(b));
        e.r   = e.dz ? 4'd0 : 4'(int'(a) % int'(b));
        e.lat = e.dz ? 0 : 8;
        sb.push_back(e);
        A = a;
        B = b;
        start = 1'b1;
        tick();
    endtask

    // Bounded wait for Finish; a timeout shows up as a wrong latency.
    task automatic wait_finish(output int lat);
        lat = 0;
        while (Finish !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        A = 8'd100;
        B = 4'd0;
        #12;
        total++;
        if ({Q, R, Finish, Dz} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs: got Q=%0d R=%0d Finish=%b Dz=%b, want all 0", Q, R, Finish, Dz);
        end
        #20;
        start = 1'b0;
        A = 8'd0;
        #8;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        int lat;
        launch(8'd154, 4'd11);
        wait_finish(lat);
        e = sb.pop_front();
        total++;
        if (lat != e.lat || Q !== e.q || R !== e.r || Dz !== e.dz) begin
            bad++;
            $display("FAIL basic_154_11: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=%0d Q=%0d R=%0d Dz=%b",
                     lat, Q, R, Dz, e.lat, e.q, e.r, e.dz);
        end
        A = 8'd3;
        B = 4'd3;
        for (int unsigned i = 0; i < 12; i++) begin
            tick();
            total++;
            if (Finish !== 1'b1 || Q !== 8'd14 || R !== 4'd0) begin
                bad++;
                $display("FAIL no_retrigger: got Finish=%b Q=%0d R=%0d, want Finish=1 Q=14 R=0", Finish, Q, R);
            end
        end
        start = 1'b0;
        tick();
        total++;
        if (Finish !== 1'b0) begin
            bad++;
            $display("FAIL finish_drop: got Finish=%b, want 0", Finish);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] as [6] = '{8'd200, 8'd255, 8'd9, 8'd0, 8'd13, 8'd3};
        logic [3:0] bs [6] = '{4'd7, 4'd1, 4'd15, 4'd5, 4'd13, 4'd4};
        exp_t e;
        int lat;
        for (int unsigned i = 0; i < 6; i++) begin
            launch(as[i], bs[i]);
            wait_finish(lat);
            e = sb.pop_front();
            total++;
            if (lat != e.lat || Q !== e.q || R !== e.r || Dz !== e.dz) begin
                bad++;
                $display("FAIL seq_%0d_%0d: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=%0d Q=%0d R=%0d Dz=%b",
                         as[i], bs[i], lat, Q, R, Dz, e.lat, e.q, e.r, e.dz);
            end
            start = 1'b0;
            tick();
            total++;
            if (Finish !== 1'b0 || Q !== e.q || R !== e.r) begin
                bad++;
                $display("FAIL seq_release: got Finish=%b Q=%0d R=%0d, want Finish=0 Q=%0d R=%0d",
                         Finish, Q, R, e.q, e.r);
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        int lat;
        launch(8'd100, 4'd0);
        wait_finish(lat);
        e = sb.pop_front();
        total++;
        if (lat != 0 || Q !== 8'hFF || R !== 4'd0 || Dz !== 1'b1) begin
            bad++;
            $display("FAIL div_zero: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=0 Q=255 R=0 Dz=1", lat, Q, R, Dz);
        end
        start = 1'b0;
        tick();
        launch(8'd154, 4'd11);
        total++;
        if (Dz !== 1'b1 || Q !== 8'hFF || Finish !== 1'b0) begin
            bad++;
            $display("FAIL dz_hold_in_calc: got Dz=%b Q=%0d Finish=%b, want Dz=1 Q=255 Finish=0", Dz, Q, Finish);
        end
        wait_finish(lat);
        e = sb.pop_front();
        total++;
        if (lat != e.lat || Q !== e.q || R !== e.r || Dz !== 1'b0) begin
            bad++;
            $display("FAIL dz_clear: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=%0d Q=%0d R=%0d Dz=0",
                     lat, Q, R, Dz, e.lat, e.q, e.r);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_ignore_inputs();
        exp_t e;
        int lat;
        launch(8'd77, 4'd6);
        tick();
        A = 8'd3;
        B = 4'd3;
        start = 1'b0;
        tick();
        start = 1'b1;
        wait_finish(lat);
        e = sb.pop_front();
        total++;
        if (lat + 2 != e.lat || Q !== e.q || R !== e.r || Dz !== 1'b0) begin
            bad++;
            $display("FAIL ignore_inputs: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=%0d Q=%0d R=%0d Dz=0",
                     lat + 2, Q, R, Dz, e.lat, e.q, e.r);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        exp_t e;
        int lat;
        launch(8'd154, 4'd11);
        tick();
        A = 8'd3;
        B = 4'd3;
        tick();
        tick();
        tick();
        total++;
        if (Finish !== 1'b0) begin
            bad++;
            $display("FAIL abort_early_finish: got Finish=%b, want 0", Finish);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({Q, R, Finish, Dz} !== 14'd0) begin
            bad++;
            $display("FAIL abort_reset: got Q=%0d R=%0d Finish=%b Dz=%b, want all 0", Q, R, Finish, Dz);
        end
        sb.delete();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        total++;
        if ({Q, R, Finish, Dz} !== 14'd0) begin
            bad++;
            $display("FAIL abort_no_residue: got Q=%0d R=%0d Finish=%b Dz=%b, want all 0", Q, R, Finish, Dz);
        end
        launch(8'd200, 4'd7);
        wait_finish(lat);
        e = sb.pop_front();
        total++;
        if (lat != e.lat || Q !== e.q || R !== e.r || Dz !== 1'b0) begin
            bad++;
            $display("FAIL after_abort: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=%0d Q=%0d R=%0d Dz=0",
                     lat, Q, R, Dz, e.lat, e.q, e.r);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_sweep();
        exp_t e;
        int lat;
        for (int unsigned a = 0; a < 256; a++) begin
            for (int unsigned b = 1; b < 16; b++) begin
                launch(8'(a), 4'(b));
                wait_finish(lat);
                e = sb.pop_front();
                total++;
                if (lat != 8 || Q !== e.q || R !== e.r || Dz !== 1'b0 ||
                    int'(Q) * int'(b) + int'(R) != int'(a) || int'(R) >= int'(b)) begin
                    bad++;
                    $display("FAIL sweep_%0d_%0d: got lat=%0d Q=%0d R=%0d Dz=%b, want lat=8 Q=%0d R=%0d Dz=0",
                             a, b, lat, Q, R, Dz, e.q, e.r);
                end
                start = 1'b0;
                tick();
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        int lat;
        launch(8'd200, 4'd7);
        wait_finish(lat);
        e = sb.pop_front();
        total++;
        if (lat != e.lat || Q !== 8'd28 || R !== 4'd4) begin
            bad++;
            $display("FAIL hold_setup: got lat=%0d Q=%0d R=%0d, want lat=8 Q=28 R=4", lat, Q, R);
        end
        start = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            tick();
            A = 8'($urandom_range(255));
            B = 4'($urandom_range(15));
            total++;
            if (Q !== 8'd28 || R !== 4'd4 || Finish !== 1'b0 || Dz !== 1'b0) begin
                bad++;
                $display("FAIL hold_idle: got Q=%0d R=%0d Finish=%b Dz=%b, want Q=28 R=4 Finish=0 Dz=0",
                         Q, R, Finish, Dz);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_div_zero();
        test_ignore_inputs();
        test_abort();
        test_sweep();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/div_8x4.md
Name: div_8x4

Overview:
- Sequential restoring divider: the inverse operation of the team's mult_4x4.
- Divides an 8-bit unsigned dividend by a 4-bit unsigned divisor and produces an 8-bit quotient and a 4-bit remainder.
- Uses the same start/Finish handshake as mult_4x4, so the two blocks are interchangeable under the existing control logic.
- Sits next to mult_4x4 in the arithmetic unit. Used for result checking, e.g. (A*B)/B == A.

Parameters:
- NW, 8, dividend and quotient width.
- DW, 4, divisor and remainder width.
- Required: DW <= NW.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  request; level-sampled in IDLE.
- A  input  NW  dividend; sampled on the capture edge only.
- B  input  DW  divisor; sampled on the capture edge only.
- Q  output  NW  quotient; registered.
- R  output  DW  remainder; registered.
- Finish  output  1  result valid; registered.
- Dz  output  1  divide-by-zero flag for the current result; registered.

Behaviour:
- Reset values (asynchronous, while reset=1): state=IDLE, Q=0, R=0, Finish=0, Dz=0, count=0, all working registers 0. Reset asserted mid-operation aborts the operation at once; no partial result is exposed.
- States:
  - IDLE: if start=1 at a rising edge (the capture edge), latch A into the working dividend and B into the working divisor, clear the partial remainder (DW+1 bits) and count.
    - B!=0: go to CALC.
    - B==0: go to DONE with Q=all ones, R=0, Dz=1, Finish=1.
  - CALC: one restoring iteration per edge, MSB of the dividend first:
    - shift the partial remainder left, bringing in the next dividend bit;
    - if partial remainder >= divisor, subtract the divisor and set quotient bit = 1; otherwise quotient bit = 0;
    - increment count.
    - On the NW-th iteration edge: load Q from the working quotient, load R from the partial remainder low DW bits, Dz=0, Finish=1, go to DONE.
  - DONE: Finish held at 1. When start=0 at an edge: Finish becomes 0 and the state returns to IDLE. Q, R and Dz keep their values.
- Latency:
  - Normal: Finish rises NW (8) edges after the capture edge.
  - Divide-by-zero: Finish rises on the capture edge itself.
- Handshake:
  - A start held high through DONE does not retrigger. A new operation needs start=0 for at least one edge in DONE or IDLE, then start=1.
  - start changes during CALC are ignored.
  - A and B changes after the capture edge are ignored.
- Output stability: Q, R and Dz change only on the edge that enters DONE, and on reset. They hold between operations; Finish=0 does not clear them.
- Arithmetic:
  - Unsigned only. The partial remainder is DW+1 bits so the compare never overflows.
  - Final R < B is guaranteed.
  - Invariant when Dz=0: Q*B + R == A.
- Boundaries:
  - A=0 gives Q=0, R=0.
  - A < B gives Q=0, R=A.
  - B=1 gives Q=A, R=0.
  - Quotient overflow cannot occur for NW-bit Q.
- Simultaneous reset and start: reset wins.

Test Plan:
1. reset=1 for 40 time units, then 0; A=154, B=11, start=1 held -> Finish=1 exactly 8 clk edges after capture, Q=14, R=0, Dz=0. Finish stays 1 while start=1, with no second operation.
2. start=0 for one edge, then A=200, B=7, start=1 -> Finish drops on the start=0 edge; after 8 edges Q=28, R=4. A=255, B=1 -> Q=255, R=0. A=9, B=15 -> Q=0, R=9.
3. A=100, B=0, start=1 -> Finish=1 and Dz=1 on the capture edge, Q=8'hFF, R=0. The next normal operation clears Dz.
4. Start A=154, B=11; change A and B to 3 and 3 at edge 2; assert reset at edge 4 -> all outputs 0 immediately, state IDLE. After reset release, a new start gives a correct result with no residue.
5. Exhaustive sweep of all A in 0..255 and B in 1..15 -> Q*B + R == A and R < B for every pair. Latency is always exactly 8 edges.
6. Q and R from scenario 2 are held while Finish=0 and start=0 for 20 cycles -> no change.
